// File: rtl/axis_snoop_sink_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axis_snoop_sink_pkg
// Brief    : Shared types for the snoop-stream sink (state, FIFO entry).
// Revision : 1.0 - initial release
// ============================================================================
package axis_snoop_sink_pkg;

    localparam int ANGLE_W = 16;

    typedef enum logic {
        ACCEPT  = 1'b0,
        DISCARD = 1'b1
    } snoop_state_t;

    typedef struct packed {
        logic               last;
        logic [ANGLE_W-1:0] data;
    } snoop_entry_t;

endpackage
`default_nettype wire

// File: rtl/axis_snoop_sink_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_fwft
// Brief    : Synchronous first-word-fall-through FIFO with pop-through-full.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 17
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_rd;
    logic             w_wr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign count = r_wr_ptr - r_rd_ptr;
    assign dout  = r_mem[r_rd_ptr[AW-1:0]];

    assign w_rd  = rd_en && !empty;
    assign w_wr  = wr_en && (!full || w_rd);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_snoop_sink.sv
`default_nettype none
// ============================================================================
// Module   : axis_snoop_sink
// Brief    : Buffers a non-stallable snoop stream into a handshaked AXIS
//            master, dropping whole packet tails on overflow.
// Revision : 1.0 - initial release
// ============================================================================
module axis_snoop_sink
    import axis_snoop_sink_pkg::*;
#(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int DATA_W                 = 16,
    parameter int DEPTH                  = 16,
    parameter int CNT_W                  = 16
) (
    input  logic                                  s00_axis_aclk,
    input  logic                                  s00_axis_aresetn,
    input  logic                                  s00_axis_tvalid,
    input  logic                                  s00_axis_tlast,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    output logic                                  s00_axis_tready,
    input  logic                                  m00_axis_tready,
    output logic                                  m00_axis_tvalid,
    output logic                                  m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic [CNT_W-1:0]                      drop_count,
    output logic                                  overflow,
    output logic [$clog2(DEPTH):0]                fill_level
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    snoop_state_t                     r_state;
    snoop_state_t                     w_state_nxt;
    logic [CNT_W-1:0]                 r_drop_count;
    logic                             r_overflow;

    snoop_entry_t                     w_wr_entry;
    snoop_entry_t                     w_head;
    logic                             w_full;
    logic                             w_empty;
    logic [$clog2(DEPTH):0]           w_count;
    logic                             w_pop;
    logic                             w_can_store;
    logic                             w_push;
    logic                             w_drop;
    logic [C_S00_AXIS_TDATA_WIDTH-1:0] w_unused_tdata;

    // Bits above DATA_W are deliberately ignored.
    assign w_unused_tdata  = s00_axis_tdata;

    assign w_wr_entry.last = s00_axis_tlast;
    assign w_wr_entry.data = ANGLE_W'(s00_axis_tdata[DATA_W-1:0]);

    assign w_pop       = !w_empty && m00_axis_tready;
    assign w_can_store = !w_full || w_pop;
    assign w_push      = s00_axis_tvalid && (r_state == ACCEPT) && w_can_store;
    assign w_drop      = s00_axis_tvalid && ((r_state == DISCARD) || !w_can_store);

    sync_fifo_fwft #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(snoop_entry_t))
    ) u_fifo (
        .clk   (s00_axis_aclk),
        .rst_n (s00_axis_aresetn),
        .wr_en (w_push),
        .rd_en (m00_axis_tready),
        .din   (w_wr_entry),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            r_state <= ACCEPT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACCEPT: begin
                if (s00_axis_tvalid && !w_can_store && !s00_axis_tlast) begin
                    w_state_nxt = DISCARD;
                end
            end
            DISCARD: begin
                if (s00_axis_tvalid && s00_axis_tlast) begin
                    w_state_nxt = ACCEPT;
                end
            end
            default: w_state_nxt = ACCEPT;
        endcase
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != c_CNT_MAX) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

    // Head fields are masked so the bus reads zero whenever nothing is valid.
    assign s00_axis_tready = 1'b1;
    assign m00_axis_tvalid = !w_empty;
    assign m00_axis_tlast  = !w_empty && w_head.last;
    assign m00_axis_tdata  = w_empty ? '0 : C_M00_AXIS_TDATA_WIDTH'(w_head.data);
    assign m00_axis_tstrb  = '1;
    assign drop_count      = r_drop_count;
    assign overflow        = r_overflow;
    assign fill_level      = w_count;

endmodule
`default_nettype wire

// File: tb/tb_axis_snoop_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_snoop_sink
// Brief    : Directed plus randomized bench against a queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_snoop_sink;

    localparam int DEPTH = 16;
    localparam int CNT_W = 4;
    localparam int FW    = $clog2(DEPTH) + 1;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              aresetn;
    logic              s_tvalid;
    logic              s_tlast;
    logic [31:0]       s_tdata;
    logic              s_tready;
    logic              m_tready;
    logic              m_tvalid;
    logic              m_tlast;
    logic [31:0]       m_tdata;
    logic [3:0]        m_tstrb;
    logic [CNT_W-1:0]  drop_count;
    logic              overflow;
    logic [FW-1:0]     fill_level;

    always #5 clk = ~clk;

    axis_snoop_sink #(
        .C_S00_AXIS_TDATA_WIDTH (32),
        .C_M00_AXIS_TDATA_WIDTH (32),
        .DATA_W                 (16),
        .DEPTH                  (DEPTH),
        .CNT_W                  (CNT_W)
    ) dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (aresetn),
        .s00_axis_tvalid  (s_tvalid),
        .s00_axis_tlast   (s_tlast),
        .s00_axis_tdata   (s_tdata),
        .s00_axis_tready  (s_tready),
        .m00_axis_tready  (m_tready),
        .m00_axis_tvalid  (m_tvalid),
        .m00_axis_tlast   (m_tlast),
        .m00_axis_tdata   (m_tdata),
        .m00_axis_tstrb   (m_tstrb),
        .drop_count       (drop_count),
        .overflow         (overflow),
        .fill_level       (fill_level)
    );

    typedef struct {
        bit        last;
        bit [15:0] data;
    } ent_t;

    ent_t q[$];
    bit   m_discard;
    int   m_drops;
    bit   m_ovf;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference: packet-level drop rules applied to a plain queue.
    task automatic model_edge(input bit rn, input bit tv, input bit tl,
                              input bit [15:0] td, input bit tr);
        bit pop;
        bit drop;
        if (!rn) begin
            q.delete();
            m_discard = 1'b0;
            m_drops   = 0;
            m_ovf     = 1'b0;
            return;
        end
        pop  = (q.size() > 0) && tr;
        drop = 1'b0;
        if (pop) void'(q.pop_front());
        if (tv) begin
            if (m_discard) begin
                drop = 1'b1;
                if (tl) m_discard = 1'b0;
            end else if (q.size() < DEPTH) begin
                q.push_back('{last: tl, data: td});
            end else begin
                drop = 1'b1;
                if (!tl) m_discard = 1'b1;
            end
        end
        if (drop) begin
            m_ovf = 1'b1;
            if (m_drops < CMAX) m_drops++;
        end
    endtask

    task automatic step(input bit rn, input bit tv, input bit tl,
                        input logic [31:0] td, input bit tr);
        aresetn  = rn;
        s_tvalid = tv;
        s_tlast  = tl;
        s_tdata  = td;
        m_tready = tr;
        @(posedge clk);
        model_edge(rn, tv, tl, td[15:0], tr);
        #1;
        chk("tvalid", 64'(m_tvalid), 64'(q.size() > 0));
        chk("tdata",  64'(m_tdata),  (q.size() > 0) ? 64'(q[0].data) : 64'd0);
        chk("tlast",  64'(m_tlast),  (q.size() > 0) ? 64'(q[0].last) : 64'd0);
        chk("fill",   64'(fill_level), 64'(q.size()));
        chk("drops",  64'(drop_count), 64'(m_drops));
        chk("ovf",    64'(overflow),   64'(m_ovf));
        chk("tstrb",  64'(m_tstrb),    64'hF);
        chk("s_rdy",  64'(s_tready),   64'd1);
    endtask

    task automatic idle(input int n, input bit tr);
        for (int i = 0; i < n; i++) step(1, 0, 0, 32'h0, tr);
    endtask

    initial begin
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b0;

        step(0, 0, 0, 32'h0, 0);
        step(0, 1, 1, 32'h5555, 1);

        // Steady flow
        for (int i = 0; i < 8; i++) step(1, 1, i == 7, 32'h1000 + i, 1);
        idle(2, 1);

        // Fill and hold, overflow into DISCARD, discard to boundary
        for (int i = 0; i < 16; i++) step(1, 1, 0, 32'h1000 + i, 0);
        idle(3, 0);
        step(1, 1, 0, 32'h1010, 0);
        step(1, 1, 0, 32'h1011, 1);
        step(1, 1, 0, 32'h1012, 1);
        step(1, 1, 1, 32'h1013, 1);
        step(1, 1, 0, 32'h2000, 1);
        step(1, 1, 1, 32'h2001, 1);
        idle(20, 1);

        // Pop-through-full, then dropped tlast word on a full FIFO
        for (int i = 0; i < 16; i++) step(1, 1, i == 15, 32'h3000 + i, 0);
        step(1, 1, 0, 32'hFFFF_ABCD, 1);
        step(1, 1, 1, 32'h3100, 0);
        step(1, 1, 0, 32'h3101, 1);
        step(1, 1, 1, 32'h3102, 1);
        idle(20, 1);

        // Reset while in DISCARD with five words buffered
        for (int i = 0; i < 16; i++) step(1, 1, 0, 32'h4000 + i, 0);
        step(1, 1, 0, 32'h4010, 0);
        idle(11, 1);
        step(0, 0, 0, 32'h0, 0);
        step(1, 1, 1, 32'h4444, 0);
        idle(2, 1);

        // Randomized traffic with varying consumer throttling
        for (int seg = 0; seg < 12; seg++) begin
            int rdy_pct;
            rdy_pct = (seg % 4) * 30;
            for (int i = 0; i < 250; i++) begin
                bit rn;
                rn = ($urandom_range(599) != 0);
                step(rn,
                     $urandom_range(99) < 80,
                     $urandom_range(5) == 0,
                     $urandom,
                     $urandom_range(99) < rdy_pct);
            end
        end
        idle(20, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
